instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset PC
// default, instruction field positions and word alignment.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SKID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, imem request FSM and a registered instruction slot, 1 instr/cycle.
// Latency: instr valid the cycle after ack; stall parks one in-flight word in an inline skid register.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_plus4
);

  fetch_state_e state, state_nxt;

  logic [31:0] pc, pc_nxt, pc_inc, target;
  logic [31:0] instr_nxt, pc4_nxt;
  logic        valid_nxt, slot_free;
  logic [31:0] skid_instr, skid_instr_nxt, skid_pc4, skid_pc4_nxt;
  logic [31:0] redirect_pc, redirect_pc_nxt;
  logic        redirect_pending, pending_nxt;

  assign pc_inc    = pc + 32'd4;
  assign target    = word_align(branch_target);
  assign slot_free = !instr_valid || !stall;
  assign imem_addr = pc;
  assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

  always_comb begin
    state_nxt       = state;
    imem_req        = 1'b0;
    pc_nxt          = pc;
    instr_nxt       = instr;
    // A valid word with no stall is consumed at this edge.
    valid_nxt       = instr_valid && stall;
    pc4_nxt         = pc_plus4;
    skid_instr_nxt  = skid_instr;
    skid_pc4_nxt    = skid_pc4;
    redirect_pc_nxt = redirect_pc;
    pending_nxt     = redirect_pending;

    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (branch_taken) pc_nxt = target;
      end
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          valid_nxt = 1'b0;
          if (imem_ack) begin
            pc_nxt      = target;
            pending_nxt = 1'b0;
          end else begin
            // Request still in flight: address must stay put until it returns.
            redirect_pc_nxt = target;
            pending_nxt     = 1'b1;
          end
        end else if (imem_ack) begin
          if (redirect_pending) begin
            pc_nxt      = redirect_pc;
            pending_nxt = 1'b0;
          end else if (slot_free) begin
            instr_nxt = imem_rdata;
            valid_nxt = 1'b1;
            pc4_nxt   = pc_inc;
            pc_nxt    = pc_inc;
          end else begin
            skid_instr_nxt = imem_rdata;
            skid_pc4_nxt   = pc_inc;
            pc_nxt         = pc_inc;
            state_nxt      = SKID;
          end
        end
      end
      SKID: begin
        if (branch_taken) begin
          valid_nxt = 1'b0;
          pc_nxt    = target;
          state_nxt = REQ;
        end else if (!stall) begin
          instr_nxt = skid_instr;
          pc4_nxt   = skid_pc4;
          valid_nxt = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pc               <= word_align(RESET_PC);
      instr            <= '0;
      instr_valid      <= 1'b0;
      pc_plus4         <= '0;
      skid_instr       <= '0;
      skid_pc4         <= '0;
      redirect_pc      <= '0;
      redirect_pending <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      instr            <= instr_nxt;
      instr_valid      <= valid_nxt;
      pc_plus4         <= pc4_nxt;
      skid_instr       <= skid_instr_nxt;
      skid_pc4         <= skid_pc4_nxt;
      redirect_pc      <= redirect_pc_nxt;
      redirect_pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stall/skid, redirects, PC wrap and reset.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc_plus4;
  logic [5:0]  opcode, funct;

  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_instr, w_pc_plus4;
  logic [5:0]  w_opcode, w_funct;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory image: each word carries addr[7:2] in both opcode and funct fields.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2], 20'h12345, a[7:2]};
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign w_imem_rdata = mem_word(w_imem_addr);

  instr_fetch u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr),
    .opcode(opcode), .funct(funct), .pc_plus4(pc_plus4)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(w_imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(w_instr_valid), .instr(w_instr),
    .opcode(w_opcode), .funct(w_funct), .pc_plus4(w_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    tick(); tick();

    chk("rst_req",    {31'b0, imem_req},    32'd0);
    chk("rst_valid",  {31'b0, instr_valid}, 32'd0);
    chk("rst_instr",  instr,                32'd0);
    chk("rst_pc4",    pc_plus4,             32'd0);
    chk("rst_addr",   imem_addr,            32'd0);
    chk("rst_waddr",  w_imem_addr,          32'hFFFF_FFFC);

    // Streaming with zero-wait memory
    reset = 1'b0; imem_ack = 1'b1;
    tick();
    chk("idle_to_req", {31'b0, imem_req},    32'd1);
    chk("first_addr",  imem_addr,            32'd0);
    chk("no_valid_c2", {31'b0, instr_valid}, 32'd0);
    chk("wrap_addr0",  w_imem_addr,          32'hFFFF_FFFC);
    tick();
    chk("valid_c3",    {31'b0, instr_valid}, 32'd1);
    chk("instr0",      instr,                mem_word(32'h0));
    chk("pc4_0",       pc_plus4,             32'd4);
    chk("addr_4",      imem_addr,            32'd4);
    chk("wrap_addr1",  w_imem_addr,          32'h0);
    chk("wrap_pc4",    w_pc_plus4,           32'h0);
    chk("wrap_instr",  w_instr,              mem_word(32'hFFFF_FFFC));
    chk("wrap_opcode", {26'b0, w_opcode},    32'h3F);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("stream_instr", instr,                mem_word(32'(4 * k)));
      chk("stream_pc4",   pc_plus4,             32'(4 * k + 4));
      chk("stream_addr",  imem_addr,            32'(4 * k + 4));
      chk("stream_valid", {31'b0, instr_valid}, 32'd1);
    end

    // Stall for three cycles while memory acks: second word parks in the skid
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_instr", instr,                mem_word(32'hC));
      chk("stall_req",   {31'b0, imem_req},    32'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_addr",  imem_addr,            32'h14);
    end
    stall = 1'b0;
    tick();
    chk("skid_out",     instr,             mem_word(32'h10));
    chk("skid_pc4",     pc_plus4,          32'h14);
    chk("skid_req",     {31'b0, imem_req}, 32'd1);
    tick();
    chk("after_skid",   instr,             mem_word(32'h14));
    chk("after_skid4",  pc_plus4,          32'h18);

    // Branch coinciding with ack; misaligned target is word-aligned
    branch_taken = 1'b1; branch_target = 32'h43;
    tick();
    branch_taken = 1'b0;
    chk("br_valid",  {31'b0, instr_valid}, 32'd0);
    chk("br_addr",   imem_addr,            32'h40);
    tick();
    chk("br_instr",  instr,                mem_word(32'h40));
    chk("br_opcode", {26'b0, opcode},      32'h10);
    chk("br_pc4",    pc_plus4,             32'h44);

    // Branch while request outstanding, ack delayed two cycles
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    chk("rd_valid",  {31'b0, instr_valid}, 32'd0);
    chk("rd_hold1",  imem_addr,            32'h44);
    tick();
    chk("rd_hold2",  imem_addr,            32'h44);
    imem_ack = 1'b1;
    tick();
    chk("rd_discard", {31'b0, instr_valid}, 32'd0);
    chk("rd_addr",    imem_addr,            32'h80);
    tick();
    chk("rd_instr",   instr,                mem_word(32'h80));
    chk("rd_opcode",  {26'b0, opcode},      32'h20);
    chk("rd_funct",   {26'b0, funct},       32'h20);

    // No ack: consumed word clears valid, address held
    imem_ack = 1'b0;
    tick();
    chk("noack_valid", {31'b0, instr_valid}, 32'd0);
    chk("noack_addr",  imem_addr,            32'h84);
    imem_ack = 1'b1;
    tick();
    chk("noack_instr", instr,                mem_word(32'h84));

    // Reset while in SKID
    stall = 1'b1;
    tick();
    chk("pre_rst_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_req",   {31'b0, imem_req},    32'd0);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr,                32'd0);
    chk("mid_rst_pc4",   pc_plus4,             32'd0);
    chk("mid_rst_addr",  imem_addr,            32'd0);
    reset = 1'b0; stall = 1'b0;
    tick();
    chk("post_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("post_rst_req",   {31'b0, imem_req},    32'd1);
    tick();
    chk("post_rst_instr", instr,                mem_word(32'h0));
    chk("post_rst_vld",   {31'b0, instr_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
